// File: rtl/dlx_pipe_pkg.sv
// Shared definitions for the DLX pipeline hazard controller:
// controller state encoding and EX operand source selects.
package dlx_pipe_pkg;

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_RUN      = 2'd1,
        ST_LD_STALL = 2'd2,
        ST_FLUSH    = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB destination scoreboard with source comparators.
// PIPE_FORWARD_EN selects load-use-only hazards plus forward selects.
import dlx_pipe_pkg::*;

module hazard_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              regwrite,
    input  logic              memread,
    input  logic              bubble,
    output logic              hazard,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b
);

    // index 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]        v_q;
    logic [2:0]        rw_q;
    logic [2:0]        mr_q;
    logic [REG_AW-1:0] rd_q [3];
    logic              ld;

    assign ld = id_valid & ~bubble;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            rw_q    <= '0;
            mr_q    <= '0;
            rd_q[0] <= '0;
            rd_q[1] <= '0;
            rd_q[2] <= '0;
        end else begin
            v_q     <= {v_q[1:0], ld};
            rw_q    <= {rw_q[1:0], ld & regwrite};
            mr_q    <= {mr_q[1:0], ld & memread};
            rd_q[2] <= rd_q[1];
            rd_q[1] <= rd_q[0];
            rd_q[0] <= ld ? rd : '0;
        end
    end

    // r0 is hard-wired zero, so it never carries a dependency
    function automatic logic hit(input logic u,
                                 input logic [REG_AW-1:0] s,
                                 input logic [REG_AW-1:0] d);
        return u && (s != '0) && (s == d);
    endfunction

    logic ex_a, ex_b, mem_a, mem_b;
    logic ex_wr, mem_wr, lu, raw;

    assign ex_a   = hit(use_rs1, rs1, rd_q[0]);
    assign ex_b   = hit(use_rs2, rs2, rd_q[0]);
    assign mem_a  = hit(use_rs1, rs1, rd_q[1]);
    assign mem_b  = hit(use_rs2, rs2, rd_q[1]);
    assign ex_wr  = v_q[0] & rw_q[0];
    assign mem_wr = v_q[1] & rw_q[1];
    assign lu     = id_valid & v_q[0] & mr_q[0] & (ex_a | ex_b);
    assign raw    = id_valid & ((ex_wr & (ex_a | ex_b))
                              | (mem_wr & (mem_a | mem_b)));

`ifdef PIPE_FORWARD_EN
    assign hazard = lu;
    assign sel_a  = !id_valid       ? FWD_RF    :
                    (ex_wr & ex_a)  ? FWD_EXMEM :
                    (mem_wr & mem_a) ? FWD_MEMWB : FWD_RF;
    assign sel_b  = !id_valid       ? FWD_RF    :
                    (ex_wr & ex_b)  ? FWD_EXMEM :
                    (mem_wr & mem_b) ? FWD_MEMWB : FWD_RF;
`else
    assign hazard = raw | lu;
    assign sel_a  = FWD_RF;
    assign sel_b  = FWD_RF;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// DLX hazard control: post-reset fill, RAW/load-use stalls, branch flush.
// Build with PIPE_FORWARD_EN to enable operand forwarding.
import dlx_pipe_pkg::*;

module pipe_hazard_ctrl #(
    parameter int FILL_CYCLES = 4,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_branch_taken,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              kill_if,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              busy
);

    localparam int CW = $clog2(FILL_CYCLES) + 1;
    localparam logic [CW-1:0] FILL_LAST = CW'(FILL_CYCLES - 1);

    hz_state_t     state, state_nx;
    logic [CW-1:0] fill_cnt;
    logic          hazard;
    logic [1:0]    sel_a, sel_b;
    logic          br;

    hazard_scoreboard #(.REG_AW(REG_AW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .id_valid (id_valid),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .use_rs1  (id_use_rs1),
        .use_rs2  (id_use_rs2),
        .rd       (id_rd),
        .regwrite (id_regwrite),
        .memread  (id_memread),
        .bubble   (bubble_ex),
        .hazard   (hazard),
        .sel_a    (sel_a),
        .sel_b    (sel_b)
    );

    assign br   = id_valid & id_branch_taken;
    assign busy = (state != ST_RUN);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
        end else begin
            state    <= state_nx;
            fill_cnt <= (state == ST_FILL) ? fill_cnt + CW'(1) : '0;
        end
    end

    // A stall outranks a branch; the branch is re-seen once ID is released
    always_comb begin
        state_nx  = state;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        kill_if   = 1'b0;
        unique case (state)
            ST_FILL: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
                if (fill_cnt == FILL_LAST) state_nx = ST_RUN;
            end
            ST_RUN, ST_LD_STALL: begin
                if (hazard) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    state_nx  = ST_LD_STALL;
                end else if (br) begin
                    kill_if  = 1'b1;
                    state_nx = ST_FLUSH;
                end else begin
                    state_nx = ST_RUN;
                end
            end
            ST_FLUSH: begin
                bubble_ex = 1'b1;
                state_nx  = ST_RUN;
            end
            default: state_nx = ST_FILL;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (!stall_id) begin
            fwd_a_sel <= bubble_ex ? FWD_RF : sel_a;
            fwd_b_sel <= bubble_ex ? FWD_RF : sel_b;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queued-expectation monitor.
// Covers both PIPE_FORWARD_EN builds.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       stall_if;
        logic       stall_id;
        logic       bubble_ex;
        logic       kill_if;
        logic       busy;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       id_regwrite, id_memread, id_branch_taken;
    logic       stall_if, stall_id, bubble_ex, kill_if, busy;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    int compared   = 0;
    int mismatched = 0;

    exp_t  exq [$];
    string nmq [$];
    exp_t  mon_e, mon_g;
    string mon_n;

    pipe_hazard_ctrl #(.FILL_CYCLES(4), .REG_AW(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .id_branch_taken (id_branch_taken),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .bubble_ex       (bubble_ex),
        .kill_if         (kill_if),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .busy            (busy)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic si, input logic sd,
                                input logic be, input logic k,
                                input logic b, input logic [1:0] fa,
                                input logic [1:0] fb);
        exp_t e;
        e = '{si, sd, be, k, b, fa, fb};
        return e;
    endfunction

    // Monitor: DUT updates on negedge, so outputs are sampled on posedge
    always @(posedge clk) begin
        if (exq.size() > 0) begin
            mon_e = exq.pop_front();
            mon_n = nmq.pop_front();
            mon_g = '{stall_if, stall_id, bubble_ex, kill_if, busy,
                      fwd_a_sel, fwd_b_sel};
            compared++;
            if (mon_g !== mon_e) begin
                mismatched++;
                $display("FAIL %s: got si/sd/bx/k/busy/fa/fb=%b exp %b",
                         mon_n, mon_g, mon_e);
            end
        end
    end

    task automatic cyc(input logic r, input logic v,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw,
                       input logic mr, input logic br,
                       input exp_t e, input string nm);
        @(negedge clk);
        #1;
        rst             = r;
        id_valid        = v;
        id_rs1          = rs1;
        id_use_rs1      = u1;
        id_rs2          = rs2;
        id_use_rs2      = u2;
        id_rd           = rd;
        id_regwrite     = rw;
        id_memread      = mr;
        id_branch_taken = br;
        exq.push_back(e);
        nmq.push_back(nm);
    endtask

    task automatic idle(input exp_t e, input string nm);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e, nm);
    endtask

    exp_t FILLV, IDLE, STRUN, STLD, RELS;

    initial begin
        FILLV = mk(1, 1, 1, 0, 1, 0, 0);
        IDLE  = mk(0, 0, 0, 0, 0, 0, 0);
        STRUN = mk(1, 1, 1, 0, 0, 0, 0);
        STLD  = mk(1, 1, 1, 0, 1, 0, 0);
        RELS  = mk(0, 0, 0, 0, 1, 0, 0);

        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0;
        id_regwrite = 0; id_memread = 0; id_branch_taken = 0;

        // reset and fill: exactly four negedges after release
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, FILLV, "rst_held");
        idle(FILLV, "fill0");
        idle(FILLV, "fill1");
        idle(FILLV, "fill2");
        idle(FILLV, "fill3");
        idle(IDLE, "run_entry");

        // r0 never forms a dependency; taken branch kills then flushes
        cyc(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, IDLE, "addi_r0");
        cyc(0, 1, 0, 1, 0, 1, 7, 1, 0, 0, IDLE, "use_r0");
        cyc(0, 1, 8, 1, 9, 1, 0, 0, 0, 1,
            mk(0, 0, 0, 1, 0, 0, 0), "br_kill");
        idle(mk(0, 0, 1, 0, 1, 0, 0), "br_flush");
        idle(IDLE, "after_flush");

`ifdef PIPE_FORWARD_EN
        // back-to-back: EX/MEM forward
        cyc(0, 1, 1, 1, 2, 1, 3, 1, 0, 0, IDLE, "add_r3");
        cyc(0, 1, 3, 1, 5, 1, 4, 1, 0, 0, IDLE, "sub_no_stall");
        idle(mk(0, 0, 0, 0, 0, 1, 0), "fwd_exmem");
        // one-instruction gap: MEM/WB forward
        cyc(0, 1, 1, 1, 2, 1, 3, 1, 0, 0, IDLE, "add_r3_b");
        idle(IDLE, "gap_nop");
        cyc(0, 1, 3, 1, 5, 1, 4, 1, 0, 0, IDLE, "sub_gap");
        idle(mk(0, 0, 0, 0, 0, 2, 0), "fwd_memwb");
        // load-use: one stall, then both operands from MEM/WB
        cyc(0, 1, 1, 1, 0, 0, 2, 1, 1, 0, IDLE, "lw_r2");
        cyc(0, 1, 2, 1, 2, 1, 6, 1, 0, 0, STRUN, "lu_stall");
        cyc(0, 1, 2, 1, 2, 1, 6, 1, 0, 0, RELS, "lu_release");
        idle(mk(0, 0, 0, 0, 0, 2, 2), "lu_fwd");
        // load-use beats a branch; kill follows one cycle later
        cyc(0, 1, 1, 1, 0, 0, 2, 1, 1, 0, IDLE, "lw_r2_b");
        cyc(0, 1, 2, 1, 9, 1, 0, 0, 0, 1, STRUN, "lu_br_stall");
        cyc(0, 1, 2, 1, 9, 1, 0, 0, 0, 1,
            mk(0, 0, 0, 1, 1, 0, 0), "lu_br_kill");
        idle(mk(0, 0, 1, 0, 1, 2, 0), "lu_br_flush");
        idle(IDLE, "lu_br_done");
`else
        // no forwarding: EX then MEM match stall, WB match does not
        cyc(0, 1, 1, 1, 2, 1, 3, 1, 0, 0, IDLE, "add_r3");
        cyc(0, 1, 3, 1, 5, 1, 4, 1, 0, 0, STRUN, "raw_stall_ex");
        cyc(0, 1, 3, 1, 5, 1, 4, 1, 0, 0, STLD, "raw_stall_mem");
        cyc(0, 1, 3, 1, 5, 1, 4, 1, 0, 0, RELS, "raw_release");
        idle(IDLE, "raw_sub_ex");
        // one-instruction gap: single MEM stall
        cyc(0, 1, 1, 1, 2, 1, 3, 1, 0, 0, IDLE, "add_r3_b");
        idle(IDLE, "gap_nop");
        cyc(0, 1, 3, 1, 0, 0, 4, 1, 0, 0, STRUN, "gap_stall");
        cyc(0, 1, 3, 1, 0, 0, 4, 1, 0, 0, RELS, "gap_release");
        idle(IDLE, "gap_done");
        // reset pulse mid-stall restarts the fill
        cyc(0, 1, 1, 1, 0, 0, 2, 1, 1, 0, IDLE, "lw_r2");
        cyc(0, 1, 2, 1, 2, 1, 6, 1, 0, 0, STRUN, "lu_stall_ex");
        cyc(0, 1, 2, 1, 2, 1, 6, 1, 0, 0, STLD, "lu_stall_mem");
        cyc(1, 1, 2, 1, 2, 1, 6, 1, 0, 0, FILLV, "rst_mid_stall");
        idle(FILLV, "refill0");
        idle(FILLV, "refill1");
        idle(FILLV, "refill2");
        idle(FILLV, "refill3");
        idle(IDLE, "rerun");
`endif

        @(posedge clk);
        #1;
        if (exq.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d left, want 0", exq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
